// File: rtl/prim_filter_pkg.sv
// Shared defaults for the multi-channel counter debouncer.
// No logic here; these constants are used only as parameter defaults.
// No flow control.
package prim_filter_pkg;

  localparam int NumChanDefault  = 8;
  localparam int CntWidthDefault = 16;

endpackage

// File: rtl/prim_filter_ctr_chan.sv
// Single debounce channel: the stored value follows the input after T+1 equal samples.
// Latency: T+1 edges from input change to filter_o; rise/fall pulse in that same first cycle.
// No backpressure; free-running every cycle, independent of en_i.
module prim_filter_ctr_chan
  import prim_filter_pkg::*;
#(
  parameter int CntWidth = CntWidthDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic                en_i,
  input  logic                filter_i,
  output logic                filter_o,
  output logic                rise_o,
  output logic                fall_o
);

  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  logic                r_filter_q;
  logic                r_stored_q;
  logic                r_rise_q;
  logic                r_fall_q;
  logic [CntWidth-1:0] r_ctr_q;
  logic [CntWidth-1:0] w_ctr_d;
  logic                w_update;

  // Stability counter: restart on any input change, clamp at T so it never wraps
  // and so a lowered threshold takes effect on the very next edge.
  always_comb begin
    w_ctr_d = r_ctr_q + CntOne;
    if (filter_i != r_filter_q) begin
      w_ctr_d = '0;
    end else if (r_ctr_q >= thresh_i) begin
      w_ctr_d = thresh_i;
    end
    w_update = (w_ctr_d == thresh_i);
  end

  // Sample history, counter, stored value and edge pulses (pulses only when enabled).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_filter_q <= 1'b0;
      r_ctr_q    <= '0;
      r_stored_q <= 1'b0;
      r_rise_q   <= 1'b0;
      r_fall_q   <= 1'b0;
    end else begin
      r_filter_q <= filter_i;
      r_ctr_q    <= w_ctr_d;
      if (w_update) begin
        r_stored_q <= filter_i;
      end
      r_rise_q <= w_update & en_i & filter_i & ~r_stored_q;
      r_fall_q <= w_update & en_i & ~filter_i & r_stored_q;
    end
  end

  // A disabled channel passes the raw input straight through.
  assign filter_o = en_i ? r_stored_q : filter_i;
  assign rise_o   = r_rise_q;
  assign fall_o   = r_fall_q;

endmodule

// File: rtl/prim_filter_ctr_multi.sv
// Multi-channel counter debouncer: NumChan independent filters sharing one threshold.
// Latency: T+1 edges input-to-filter_o per channel; event_o is combinational on the pulses.
// No backpressure; every channel updates every cycle.
module prim_filter_ctr_multi
  import prim_filter_pkg::*;
#(
  parameter int NumChan  = NumChanDefault,
  parameter int CntWidth = CntWidthDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic [NumChan-1:0]  en_i,
  input  logic [NumChan-1:0]  filter_i,
  output logic [NumChan-1:0]  filter_o,
  output logic [NumChan-1:0]  rise_o,
  output logic [NumChan-1:0]  fall_o,
  output logic                event_o
);

  for (genvar g = 0; g < NumChan; g++) begin : g_chan
    prim_filter_ctr_chan #(
      .CntWidth (CntWidth)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .thresh_i (thresh_i),
      .en_i     (en_i[g]),
      .filter_i (filter_i[g]),
      .filter_o (filter_o[g]),
      .rise_o   (rise_o[g]),
      .fall_o   (fall_o[g])
    );
  end

  assign event_o = |(rise_o | fall_o);

endmodule
